// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: CPU valid/ready port to strobed memory bus.
// One strobe per transaction, latency counter, halt stretch, timeout.
module cpu_mem_bridge #(
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int ReadLatency   = 1,
  parameter int TimeoutCycles = 0,
  parameter logic [DataWidth-1:0] ErrorData = '1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    cpu_valid_i,
  input  logic [AddressWidth-1:0] cpu_addr_i,
  input  logic [DataWidth-1:0]    cpu_wdata_i,
  input  logic [DataWidth/8-1:0]  cpu_wstrb_i,
  output logic                    cpu_ready_o,
  output logic [DataWidth-1:0]    cpu_rdata_o,
  output logic                    cpu_err_o,
  input  logic                    halt_i,
  output logic [AddressWidth-1:0] address_o,
  output logic [DataWidth-1:0]    data_o,
  input  logic [DataWidth-1:0]    data_i,
  output logic                    we_o,
  output logic [DataWidth/8-1:0]  we_ram_o
);

  localparam int StrbW = DataWidth / 8;
  localparam int CntW  =
    (ReadLatency > 1) ? $clog2(ReadLatency) : 1;
  localparam int TcntW =
    (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [StrbW-1:0]        wstrb_q, wstrb_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [TcntW-1:0]        tcnt_q, tcnt_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             tnext;
  logic                    is_wr;

  assign is_wr       = |wstrb_q;
  assign tnext       = 32'(tcnt_q) + 32'd1;
  assign data_o      = wdata_q;
  assign cpu_rdata_o = rdata_q;
  assign cpu_err_o   = err_q;
  assign cpu_ready_o = (state_q == RESP);

  // State and datapath registers; reset discards any transaction.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counters and bus strobes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    address_o = '0;
    we_o      = 1'b0;
    we_ram_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_valid_i && !halt_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          wstrb_d = cpu_wstrb_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!halt_i) begin
          address_o = addr_q;
          if (is_wr) begin
            we_o     = 1'b1;
            we_ram_o = wstrb_q;
            err_d    = 1'b0;
            state_d  = RESP;
          end else begin
            cnt_d   = CntW'(ReadLatency - 1);
            tcnt_d  = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (halt_i) begin
          if (!(&tcnt_q))
            tcnt_d = tcnt_q + TcntW'(1);
          if (TimeoutCycles > 0 &&
              tnext >= 32'(TimeoutCycles)) begin
            rdata_d = ErrorData;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end else if (cnt_q == '0) begin
          rdata_d = data_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
